// File: rtl/palette_ram.sv
// Multi-bank writable colour lookup table with a 2-cycle lookup pipeline,
// per-pixel dim shift and frame-synchronised display-bank swapping.
module palette_ram #(
  parameter int IDX_W = 5,
  parameter int CH_W  = 4,
  parameter int BANKS = 2,
  localparam int BNK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_valid,
  input  logic [IDX_W-1:0]  index,
  input  logic [1:0]        dim,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_valid,
  input  logic              wr_en,
  input  logic [BNK_W-1:0]  wr_bank,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_data,
  input  logic              bank_req,
  input  logic [BNK_W-1:0]  bank_req_id,
  input  logic              frame_start,
  output logic [BNK_W-1:0]  active_bank,
  output logic              swap_pending
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int RGB_W = 3 * CH_W;

  // Valid semantics: there is no back-pressure. Every cycle with pix_valid=1
  // produces exactly one cycle with out_valid=1 two clocks later, in order.

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} swap_state_e;

  swap_state_e      state_q, state_d;
  logic [BNK_W-1:0] pend_id_q, pend_id_d;
  logic [BNK_W-1:0] active_bank_q, active_bank_d;

  logic [RGB_W-1:0] mem_q [BANKS*DEPTH];
  logic             mem_we;

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_dim_q, s1_dim_d;
  logic [RGB_W-1:0] s1_rgb_q, s1_rgb_d;

  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic             req_ok;

  // Bank swap FSM; a request coinciding with frame_start takes effect at once.
  always_comb begin
    state_d       = state_q;
    pend_id_d     = pend_id_q;
    active_bank_d = active_bank_q;
    req_ok        = bank_req && (32'(bank_req_id) < BANKS);
    if (req_ok && frame_start) begin
      active_bank_d = bank_req_id;
      state_d       = IDLE;
    end else if (req_ok) begin
      pend_id_d = bank_req_id;
      state_d   = PENDING;
    end else if (frame_start && state_q == PENDING) begin
      active_bank_d = pend_id_q;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      pend_id_q     <= '0;
      active_bank_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_id_q     <= pend_id_d;
      active_bank_q <= active_bank_d;
    end
  end

  // Writes to nonexistent banks are dropped; memory is never reset.
  assign mem_we = wr_en && (32'(wr_bank) < BANKS);

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // S1 reads the pre-write contents, so a colliding write is seen one cycle later.
  always_comb begin
    s1_valid_d = pix_valid;
    s1_dim_d   = dim;
    s1_rgb_d   = mem_q[{active_bank_q, index}];
  end

  always_comb begin
    out_valid_d = s1_valid_q;
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    if (s1_valid_q) begin
      red_d   = s1_rgb_q[2*CH_W +: CH_W] >> s1_dim_q;
      green_d = s1_rgb_q[CH_W   +: CH_W] >> s1_dim_q;
      blue_d  = s1_rgb_q[0      +: CH_W] >> s1_dim_q;
    end
  end

  always_ff @(posedge Clk) begin
    s1_dim_q <= s1_dim_d;
    s1_rgb_q <= s1_rgb_d;
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign out_valid    = out_valid_q;
  assign active_bank  = active_bank_q;
  assign swap_pending = (state_q == PENDING);

endmodule

// File: tb/tb_palette_ram.sv
// Directed bench for palette_ram: vector table for lookups and dimming, plus
// hand sequences for streaming, bank swaps, write/read collision and reset.
module tb_palette_ram;

  logic        Clk;
  logic        Reset;
  logic        pix_valid;
  logic [4:0]  index;
  logic [1:0]  dim;
  logic [3:0]  red, green, blue;
  logic        out_valid;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;
  logic        bank_req;
  logic [0:0]  bank_req_id;
  logic        frame_start;
  logic [0:0]  active_bank;
  logic        swap_pending;

  int total = 0;
  int bad   = 0;

  logic [11:0] model [2][32];
  logic [12:0] exp_q[$];

  typedef struct {
    logic [4:0] idx;
    logic [1:0] dm;
    logic [3:0] er;
    logic [3:0] eg;
    logic [3:0] eb;
  } vec_t;

  vec_t vecs[10];

  palette_ram dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .index(index), .dim(dim),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .bank_req(bank_req), .bank_req_id(bank_req_id), .frame_start(frame_start),
    .active_bank(active_bank), .swap_pending(swap_pending)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic write_entry(input logic [0:0] b, input logic [4:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    model[b][a] = d;
  endtask

  task automatic lookup(input logic [4:0] i, input logic [1:0] d);
    pix_valid = 1'b1; index = i; dim = d;
    step();
    pix_valid = 1'b0;
    step();
  endtask

  function automatic logic [11:0] pat(input int b, input int i);
    logic [4:0] v;
    v = 5'(i);
    if (b == 0) pat = {v[3:0], v[4:1], ~v[3:0]};
    else        pat = {v[3:0], 4'h9, ~v[3:0]};
  endfunction

  initial begin
    Reset = 1'b1; pix_valid = 1'b0; index = '0; dim = '0;
    wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    bank_req = 1'b0; bank_req_id = '0; frame_start = 1'b0;
    step();
    step();
    Reset = 1'b0;
    check("reset_rgb", {20'd0, red, green, blue}, 32'h0);
    check("reset_ctl", {29'd0, out_valid, active_bank, swap_pending}, 32'h0);

    // Load both banks; bank0 addr5/addr7 get the documented values.
    for (int i = 0; i < 32; i++) begin
      write_entry(1'b0, 5'(i), (i == 5) ? 12'hA3C : (i == 7) ? 12'h111 : pat(0, i));
      write_entry(1'b1, 5'(i), pat(1, i));
    end

    vecs[0] = '{5'd5,  2'd0, 4'hA, 4'h3, 4'hC};
    vecs[1] = '{5'd5,  2'd1, 4'h5, 4'h1, 4'h6};
    vecs[2] = '{5'd5,  2'd2, 4'h2, 4'h0, 4'h3};
    vecs[3] = '{5'd5,  2'd3, 4'h1, 4'h0, 4'h1};
    vecs[4] = '{5'd7,  2'd0, 4'h1, 4'h1, 4'h1};
    vecs[5] = '{5'd7,  2'd1, 4'h0, 4'h0, 4'h0};
    vecs[6] = '{5'd0,  2'd0, 4'h0, 4'h0, 4'hF};
    vecs[7] = '{5'd0,  2'd2, 4'h0, 4'h0, 4'h3};
    vecs[8] = '{5'd31, 2'd0, 4'hF, 4'hF, 4'h0};
    vecs[9] = '{5'd31, 2'd1, 4'h7, 4'h7, 4'h0};
    for (int k = 0; k < 10; k++) begin
      lookup(vecs[k].idx, vecs[k].dm);
      check($sformatf("vec%0d", k), {19'd0, out_valid, red, green, blue},
            {19'd0, 1'b1, vecs[k].er, vecs[k].eg, vecs[k].eb});
    end
    step();
    check("idle_zero", {19'd0, out_valid, red, green, blue}, 32'h0);

    // Back-to-back stream of every index; scoreboard must drain with no bubbles.
    for (int c = 0; c < 34; c++) begin
      if (c < 32) begin
        pix_valid = 1'b1; index = 5'(c); dim = 2'd0;
        exp_q.push_back({1'b1, model[0][c]});
      end else begin
        pix_valid = 1'b0;
      end
      step();
      if (c >= 1 && c <= 32) begin
        check($sformatf("stream%0d", c - 1), {19'd0, out_valid, red, green, blue},
              {19'd0, exp_q.pop_front()});
      end else if (c == 33) begin
        check("stream_end", {31'd0, out_valid}, 32'h0);
      end
    end
    check("stream_drain", exp_q.size(), 32'd0);

    // Deferred swap: pending until frame_start; pixel at the swap edge uses bank0.
    bank_req = 1'b1; bank_req_id = 1'b1;
    step();
    bank_req = 1'b0;
    check("swap_wait", {30'd0, active_bank, swap_pending}, 32'h1);
    step();
    check("swap_hold", {30'd0, active_bank, swap_pending}, 32'h1);
    pix_valid = 1'b1; index = 5'd5; dim = 2'd0; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("swap_done", {30'd0, active_bank, swap_pending}, 32'h2);
    step();
    pix_valid = 1'b0;
    check("swap_old_px", {19'd0, out_valid, red, green, blue}, {19'd0, 1'b1, 12'hA3C});
    step();
    check("swap_new_px", {19'd0, out_valid, red, green, blue}, {19'd0, 1'b1, pat(1, 5)});

    // frame_start while idle changes nothing.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("fs_idle", {30'd0, active_bank, swap_pending}, 32'h2);

    // Latest request wins.
    bank_req = 1'b1; bank_req_id = 1'b0;
    step();
    bank_req_id = 1'b1;
    step();
    bank_req = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("latest_wins", {30'd0, active_bank, swap_pending}, 32'h2);

    // Request and frame_start together apply immediately.
    bank_req = 1'b1; bank_req_id = 1'b0; frame_start = 1'b1;
    step();
    bank_req = 1'b0; frame_start = 1'b0;
    check("req_with_fs", {30'd0, active_bank, swap_pending}, 32'h0);

    // Same-cycle write and read of bank0 addr7 returns old data first.
    wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 5'd7; wr_data = 12'hFFF;
    pix_valid = 1'b1; index = 5'd7; dim = 2'd0;
    step();
    wr_en = 1'b0;
    model[0][7] = 12'hFFF;
    step();
    pix_valid = 1'b0;
    check("collide_old", {19'd0, out_valid, red, green, blue}, {19'd0, 1'b1, 12'h111});
    step();
    check("collide_new", {19'd0, out_valid, red, green, blue}, {19'd0, 1'b1, 12'hFFF});

    // Reset with bank1 active, a request pending and the pipeline full.
    bank_req = 1'b1; bank_req_id = 1'b1; frame_start = 1'b1;
    step();
    bank_req_id = 1'b0; frame_start = 1'b0;
    pix_valid = 1'b1; index = 5'd5;
    step();
    bank_req = 1'b0;
    step();
    check("pre_reset", {30'd0, active_bank, swap_pending}, 32'h3);
    Reset = 1'b1; pix_valid = 1'b0;
    step();
    Reset = 1'b0;
    check("rst_rgb", {19'd0, out_valid, red, green, blue}, 32'h0);
    check("rst_ctl", {30'd0, active_bank, swap_pending}, 32'h0);
    step();
    check("rst_kill2", {31'd0, out_valid}, 32'h0);
    lookup(5'd5, 2'd0);
    check("rst_mem_kept", {19'd0, out_valid, red, green, blue}, {19'd0, 1'b1, 12'hA3C});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
